// File: rtl/usbh_root_ports.sv
// Multi-port USB host root-port block: per-port connect debounce, speed detect,
// timed bus reset with enable FSM, and packet-boundary UTMI routing to one port.
module usbh_root_ports #(
  parameter int unsigned NUM_PORTS       = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4800,
  parameter int unsigned RESET_CYCLES    = 480000,
  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [7:0]             utmi_data_out_i,
  input  logic                   utmi_txvalid_i,
  output logic                   utmi_txready_o,
  output logic [7:0]             utmi_data_in_o,
  output logic                   utmi_rxvalid_o,
  output logic                   utmi_rxactive_o,
  output logic                   utmi_rxerror_o,
  output logic [1:0]             utmi_linestate_o,
  output logic [8*NUM_PORTS-1:0] port_data_out_o,
  output logic [NUM_PORTS-1:0]   port_txvalid_o,
  input  logic [NUM_PORTS-1:0]   port_txready_i,
  input  logic [8*NUM_PORTS-1:0] port_data_in_i,
  input  logic [NUM_PORTS-1:0]   port_rxvalid_i,
  input  logic [NUM_PORTS-1:0]   port_rxactive_i,
  input  logic [NUM_PORTS-1:0]   port_rxerror_i,
  input  logic [2*NUM_PORTS-1:0] port_linestate_i,
  output logic [NUM_PORTS-1:0]   port_reset_assert_o,
  input  logic [PW-1:0]          port_sel_i,
  output logic [PW-1:0]          active_port_o,
  input  logic [NUM_PORTS-1:0]   port_reset_req_i,
  input  logic [NUM_PORTS-1:0]   port_change_clr_i,
  output logic [NUM_PORTS-1:0]   port_connected_o,
  output logic [NUM_PORTS-1:0]   port_enabled_o,
  output logic [NUM_PORTS-1:0]   port_lowspeed_o,
  output logic [NUM_PORTS-1:0]   port_change_o
);

  localparam int unsigned CNT_MAX = (DEBOUNCE_CYCLES > RESET_CYCLES) ? DEBOUNCE_CYCLES : RESET_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned PW1     = PW + 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(CNT_MAX);

  typedef enum logic [1:0] {
    ST_DISC  = 2'd0,
    ST_CONN  = 2'd1,
    ST_RESET = 2'd2,
    ST_EN    = 2'd3
  } port_state_t;

  logic [NUM_PORTS-1:0] w_en;
  logic [PW-1:0]        r_active;

  logic       w_act_en;
  logic       w_act_txready;
  logic       w_act_rxvalid;
  logic       w_act_rxactive;
  logic       w_act_rxerror;
  logic [7:0] w_act_data;
  logic [1:0] w_act_ls;
  logic       w_sel_ok;

  for (genvar n = 0; n < NUM_PORTS; n++) begin : g_port
    port_state_t   r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_first;
    logic          r_conn;
    logic          r_en;
    logic          r_low;
    logic          r_chg;
    logic          r_rst_as;
    logic [1:0]    w_ls;
    logic          w_qual;
    logic [CW-1:0] w_cnt_inc;

    assign w_ls      = port_linestate_i[2*n +: 2];
    assign w_qual    = (w_ls == 2'b01) || (w_ls == 2'b10);
    assign w_cnt_inc = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CW'(1);

    // Per-port state machine; status flags are registered alongside the state.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_state  <= ST_DISC;
        r_cnt    <= '0;
        r_first  <= 2'b00;
        r_conn   <= 1'b0;
        r_en     <= 1'b0;
        r_low    <= 1'b0;
        r_chg    <= 1'b0;
        r_rst_as <= 1'b0;
      end else begin
        // A change set later in this block overrides the clear.
        if (port_change_clr_i[n]) r_chg <= 1'b0;
        case (r_state)
          ST_DISC: begin
            if (w_qual && (r_cnt == '0 || w_ls == r_first)) begin
              if (r_cnt == DEB_LAST) begin
                r_state <= ST_CONN;
                r_cnt   <= '0;
                r_conn  <= 1'b1;
                r_low   <= (w_ls == 2'b10);
                r_chg   <= 1'b1;
              end else begin
                r_cnt <= w_cnt_inc;
                if (r_cnt == '0) r_first <= w_ls;
              end
            end else begin
              r_cnt <= '0;
            end
          end
          ST_CONN, ST_EN: begin
            if (port_reset_req_i[n]) begin
              r_state  <= ST_RESET;
              r_cnt    <= '0;
              r_en     <= 1'b0;
              r_rst_as <= 1'b1;
            end else if (w_ls == 2'b00) begin
              if (r_cnt == DEB_LAST) begin
                r_state <= ST_DISC;
                r_cnt   <= '0;
                r_conn  <= 1'b0;
                r_en    <= 1'b0;
                r_low   <= 1'b0;
                r_chg   <= 1'b1;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end else begin
              r_cnt <= '0;
            end
          end
          ST_RESET: begin
            if (r_cnt == RST_LAST) begin
              r_state  <= ST_EN;
              r_cnt    <= '0;
              r_en     <= 1'b1;
              r_rst_as <= 1'b0;
              r_chg    <= 1'b1;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          default: begin
            r_state <= ST_DISC;
            r_cnt   <= '0;
          end
        endcase
      end
    end

    assign w_en[n]                = r_en;
    assign port_connected_o[n]    = r_conn;
    assign port_lowspeed_o[n]     = r_low;
    assign port_change_o[n]       = r_chg;
    assign port_reset_assert_o[n] = r_rst_as;
  end

  assign port_enabled_o = w_en;
  assign active_port_o  = r_active;

  // Gather the active port's upstream-facing signals.
  always_comb begin
    w_act_en       = 1'b0;
    w_act_txready  = 1'b0;
    w_act_rxvalid  = 1'b0;
    w_act_rxactive = 1'b0;
    w_act_rxerror  = 1'b0;
    w_act_data     = 8'h00;
    w_act_ls       = 2'b00;
    for (int n = 0; n < NUM_PORTS; n++) begin
      if (r_active == PW'(n)) begin
        w_act_en       = w_en[n];
        w_act_txready  = port_txready_i[n];
        w_act_rxvalid  = port_rxvalid_i[n];
        w_act_rxactive = port_rxactive_i[n];
        w_act_rxerror  = port_rxerror_i[n];
        w_act_data     = port_data_in_i[8*n +: 8];
        w_act_ls       = port_linestate_i[2*n +: 2];
      end
    end
  end

  // TX fan-out: only an enabled active port sees the controller's stream.
  always_comb begin
    port_txvalid_o  = '0;
    port_data_out_o = '0;
    for (int n = 0; n < NUM_PORTS; n++) begin
      if (r_active == PW'(n) && w_en[n]) begin
        port_txvalid_o[n]          = utmi_txvalid_i;
        port_data_out_o[8*n +: 8]  = utmi_data_out_i;
      end
    end
  end

  // Without an enabled port, TX bytes are accepted and dropped.
  assign utmi_txready_o   = w_act_en ? w_act_txready : utmi_txvalid_i;
  assign utmi_data_in_o   = w_act_en ? w_act_data : 8'h00;
  assign utmi_rxvalid_o   = w_act_en & w_act_rxvalid;
  assign utmi_rxactive_o  = w_act_en & w_act_rxactive;
  assign utmi_rxerror_o   = w_act_en & w_act_rxerror;
  assign utmi_linestate_o = w_act_ls;

  assign w_sel_ok = ({1'b0, port_sel_i} < PW1'(NUM_PORTS));

  // Port selection only moves while the bus is idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_active <= '0;
    end else if (!utmi_txvalid_i && !w_act_rxactive && w_sel_ok) begin
      r_active <= port_sel_i;
    end
  end

endmodule

// File: tb/tb_usbh_root_ports.sv
// Randomized + directed bench for usbh_root_ports against a behavioural port model.
module tb_usbh_root_ports;

  localparam int NP  = 2;
  localparam int DEB = 4;
  localparam int RST = 8;
  localparam int PW  = 1;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [7:0]        utmi_data_out_i;
  logic              utmi_txvalid_i;
  logic              utmi_txready_o;
  logic [7:0]        utmi_data_in_o;
  logic              utmi_rxvalid_o, utmi_rxactive_o, utmi_rxerror_o;
  logic [1:0]        utmi_linestate_o;
  logic [8*NP-1:0]   port_data_out_o;
  logic [NP-1:0]     port_txvalid_o;
  logic [NP-1:0]     port_txready_i;
  logic [8*NP-1:0]   port_data_in_i;
  logic [NP-1:0]     port_rxvalid_i, port_rxactive_i, port_rxerror_i;
  logic [2*NP-1:0]   port_linestate_i;
  logic [NP-1:0]     port_reset_assert_o;
  logic [PW-1:0]     port_sel_i;
  logic [PW-1:0]     active_port_o;
  logic [NP-1:0]     port_reset_req_i, port_change_clr_i;
  logic [NP-1:0]     port_connected_o, port_enabled_o, port_lowspeed_o, port_change_o;

  usbh_root_ports #(.NUM_PORTS(NP), .DEBOUNCE_CYCLES(DEB), .RESET_CYCLES(RST)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .utmi_data_out_i(utmi_data_out_i), .utmi_txvalid_i(utmi_txvalid_i),
    .utmi_txready_o(utmi_txready_o), .utmi_data_in_o(utmi_data_in_o),
    .utmi_rxvalid_o(utmi_rxvalid_o), .utmi_rxactive_o(utmi_rxactive_o),
    .utmi_rxerror_o(utmi_rxerror_o), .utmi_linestate_o(utmi_linestate_o),
    .port_data_out_o(port_data_out_o), .port_txvalid_o(port_txvalid_o),
    .port_txready_i(port_txready_i), .port_data_in_i(port_data_in_i),
    .port_rxvalid_i(port_rxvalid_i), .port_rxactive_i(port_rxactive_i),
    .port_rxerror_i(port_rxerror_i), .port_linestate_i(port_linestate_i),
    .port_reset_assert_o(port_reset_assert_o), .port_sel_i(port_sel_i),
    .active_port_o(active_port_o), .port_reset_req_i(port_reset_req_i),
    .port_change_clr_i(port_change_clr_i), .port_connected_o(port_connected_o),
    .port_enabled_o(port_enabled_o), .port_lowspeed_o(port_lowspeed_o),
    .port_change_o(port_change_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: run lengths and a reset countdown per port.
  bit       m_conn [NP];
  bit       m_en   [NP];
  bit       m_low  [NP];
  bit       m_chg  [NP];
  int       m_run  [NP];
  bit [1:0] m_runv [NP];
  int       m_se0  [NP];
  int       m_rleft[NP];
  int       m_act;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int p = 0; p < NP; p++) begin
      m_conn[p] = 0; m_en[p] = 0; m_low[p] = 0; m_chg[p] = 0;
      m_run[p] = 0; m_runv[p] = 0; m_se0[p] = 0; m_rleft[p] = 0;
    end
    m_act = 0;
  endfunction

  function automatic void model_step();
    if (rst_i) begin
      model_reset();
      return;
    end
    if (!utmi_txvalid_i && !port_rxactive_i[m_act] && int'(port_sel_i) < NP)
      m_act = int'(port_sel_i);
    for (int p = 0; p < NP; p++) begin
      bit [1:0] ls;
      bit set;
      ls  = port_linestate_i[2*p +: 2];
      set = 0;
      if (!m_conn[p]) begin
        if ((ls == 2'b01 || ls == 2'b10) && (m_run[p] == 0 || ls == m_runv[p])) begin
          m_runv[p] = ls;
          m_run[p]++;
          if (m_run[p] == DEB) begin
            m_conn[p] = 1; m_low[p] = (ls == 2'b10); set = 1;
            m_run[p] = 0; m_se0[p] = 0;
          end
        end else begin
          m_run[p] = 0;
        end
      end else if (m_rleft[p] > 0) begin
        m_rleft[p]--;
        if (m_rleft[p] == 0) begin m_en[p] = 1; set = 1; end
      end else if (port_reset_req_i[p]) begin
        m_rleft[p] = RST; m_en[p] = 0; m_se0[p] = 0;
      end else if (ls == 2'b00) begin
        m_se0[p]++;
        if (m_se0[p] == DEB) begin
          m_conn[p] = 0; m_en[p] = 0; m_low[p] = 0; set = 1;
          m_se0[p] = 0; m_run[p] = 0;
        end
      end else begin
        m_se0[p] = 0;
      end
      if (set) m_chg[p] = 1;
      else if (port_change_clr_i[p]) m_chg[p] = 0;
    end
  endfunction

  task automatic check_regs();
    logic [NP-1:0] ec, ee, el, eg, er;
    for (int p = 0; p < NP; p++) begin
      ec[p] = m_conn[p]; ee[p] = m_en[p]; el[p] = m_low[p];
      eg[p] = m_chg[p];  er[p] = (m_rleft[p] > 0);
    end
    chk("connected", port_connected_o, ec);
    chk("enabled", port_enabled_o, ee);
    chk("lowspeed", port_lowspeed_o, el);
    chk("change", port_change_o, eg);
    chk("reset_assert", port_reset_assert_o, er);
    chk("active_port", active_port_o, m_act);
  endtask

  task automatic check_comb();
    logic [NP-1:0]   etv;
    logic [8*NP-1:0] ed;
    bit aen;
    etv = '0; ed = '0;
    aen = m_en[m_act];
    if (aen) begin
      etv[m_act] = utmi_txvalid_i;
      ed[8*m_act +: 8] = utmi_data_out_i;
    end
    chk("port_txvalid", port_txvalid_o, etv);
    chk("port_data_out", port_data_out_o, ed);
    chk("txready", utmi_txready_o, aen ? port_txready_i[m_act] : utmi_txvalid_i);
    chk("rx_data", utmi_data_in_o, aen ? port_data_in_i[8*m_act +: 8] : 8'h00);
    chk("rx_status", {utmi_rxvalid_o, utmi_rxactive_o, utmi_rxerror_o},
        aen ? {port_rxvalid_i[m_act], port_rxactive_i[m_act], port_rxerror_i[m_act]} : 3'b000);
    chk("linestate", utmi_linestate_o, port_linestate_i[2*m_act +: 2]);
  endtask

  // One clock: inputs already set at the falling edge.
  task automatic cycle();
    #1;
    check_comb();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_regs();
  endtask

  task automatic rand_inputs();
    for (int p = 0; p < NP; p++) begin
      if ($urandom_range(9) == 0) port_linestate_i[2*p +: 2] = 2'($urandom_range(3));
      if ($urandom_range(5) == 0) port_rxactive_i[p] = ~port_rxactive_i[p];
      port_rxvalid_i[p]    = 1'($urandom_range(1));
      port_rxerror_i[p]    = ($urandom_range(7) == 0);
      port_txready_i[p]    = 1'($urandom_range(1));
      port_reset_req_i[p]  = ($urandom_range(15) == 0);
      port_change_clr_i[p] = ($urandom_range(7) == 0);
      port_data_in_i[8*p +: 8] = 8'($urandom);
    end
    if ($urandom_range(3) == 0) utmi_txvalid_i = ~utmi_txvalid_i;
    utmi_data_out_i = 8'($urandom);
    if ($urandom_range(5) == 0) port_sel_i = PW'($urandom_range(1));
    rst_i = ($urandom_range(399) == 0);
  endtask

  initial begin
    int n;
    logic [7:0] bytes [3];
    bytes[0] = 8'h2D; bytes[1] = 8'h00; bytes[2] = 8'h10;

    rst_i = 1; utmi_data_out_i = 0; utmi_txvalid_i = 0;
    port_txready_i = 0; port_data_in_i = 0; port_rxvalid_i = 0;
    port_rxactive_i = 0; port_rxerror_i = 0; port_linestate_i = 0;
    port_sel_i = 0; port_reset_req_i = 0; port_change_clr_i = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_i = 0;
    check_regs();
    chk("rst_linestate_p0", utmi_linestate_o, port_linestate_i[1:0]);

    // Port 1 full-speed connect.
    port_linestate_i[3:2] = 2'b01;
    repeat (3) cycle();
    chk("p1_not_yet", port_connected_o[1], 1'b0);
    cycle();
    chk("p1_conn", port_connected_o[1], 1'b1);
    chk("p1_change", port_change_o[1], 1'b1);
    chk("p1_fs", port_lowspeed_o[1], 1'b0);

    // Port 0 low-speed connect with an SE0 glitch.
    port_linestate_i[1:0] = 2'b10;
    repeat (3) cycle();
    port_linestate_i[1:0] = 2'b00;
    cycle();
    port_linestate_i[1:0] = 2'b10;
    repeat (3) cycle();
    chk("p0_glitch_noconn", port_connected_o[0], 1'b0);
    cycle();
    chk("p0_conn", port_connected_o[0], 1'b1);
    chk("p0_ls", port_lowspeed_o[0], 1'b1);

    // Bus reset of port 0 with a redundant request mid-reset.
    port_reset_req_i[0] = 1;
    cycle();
    port_reset_req_i[0] = 0;
    chk("p0_rst_start", port_reset_assert_o[0], 1'b1);
    n = 1;
    for (int i = 0; i < 20 && port_reset_assert_o[0]; i++) begin
      port_reset_req_i[0] = (i == 3);
      cycle();
      if (port_reset_assert_o[0]) n++;
    end
    port_reset_req_i[0] = 0;
    chk("p0_rst_len", n, RST);
    chk("p0_en", port_enabled_o[0], 1'b1);
    chk("p0_en_ls", port_lowspeed_o[0], 1'b1);

    // Transmit through enabled port 0.
    port_sel_i = 0; port_txready_i = 2'b11;
    for (int i = 0; i < 3; i++) begin
      utmi_txvalid_i = 1; utmi_data_out_i = bytes[i];
      cycle();
      chk("tx_byte", port_data_out_o[7:0], bytes[i]);
      chk("tx_valid", port_txvalid_o, 2'b01);
    end
    port_sel_i = 1;
    repeat (2) cycle();
    chk("sel_held_busy", active_port_o, 1'b0);
    utmi_txvalid_i = 0;
    cycle();
    chk("sel_taken_idle", active_port_o, 1'b1);

    // Active port 1 only connected: TX discarded, RX blocked.
    utmi_txvalid_i = 1; utmi_data_out_i = 8'hA5;
    port_rxactive_i[1] = 1; port_rxvalid_i[1] = 1; port_data_in_i[15:8] = 8'h33;
    cycle();
    chk("conn_txvalid", port_txvalid_o, 2'b00);
    chk("conn_txready", utmi_txready_o, 1'b1);
    chk("conn_rxactive", utmi_rxactive_o, 1'b0);
    utmi_txvalid_i = 0; port_rxactive_i[1] = 0; port_rxvalid_i[1] = 0; port_sel_i = 0;
    cycle();
    chk("back_to_p0", active_port_o, 1'b0);

    // Disconnect of enabled port 0; clear collides with the new change.
    port_change_clr_i[0] = 1;
    cycle();
    port_change_clr_i[0] = 0;
    chk("chg_cleared", port_change_o[0], 1'b0);
    port_linestate_i[1:0] = 2'b00;
    repeat (3) cycle();
    chk("p0_still_en", port_enabled_o[0], 1'b1);
    port_change_clr_i[0] = 1;
    cycle();
    port_change_clr_i[0] = 0;
    chk("p0_disc", port_connected_o[0], 1'b0);
    chk("p0_disc_en", port_enabled_o[0], 1'b0);
    chk("p0_set_wins", port_change_o[0], 1'b1);
    chk("p0_disc_ls", port_lowspeed_o[0], 1'b0);

    // Reset mid bus-reset of port 1.
    port_reset_req_i[1] = 1;
    cycle();
    port_reset_req_i[1] = 0;
    repeat (2) cycle();
    chk("p1_in_rst", port_reset_assert_o[1], 1'b1);
    rst_i = 1;
    cycle();
    rst_i = 0;
    chk("rst_status", {port_connected_o, port_enabled_o, port_lowspeed_o,
                       port_change_o, port_reset_assert_o}, 10'd0);
    chk("rst_active", active_port_o, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rand_inputs();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/usbh_root_ports.md
# usbh_root_ports

Parametrised multi-port root-port block for the USB host. Sits between one `usbh_host_controller` UTMI interface and NUM_PORTS `usb_fs_phy` instances. Per port, it provides:
- connect/disconnect debounce,
- speed detection,
- timed bus-reset generation with an enable state machine.

It also routes the controller's single UTMI stream to one selected, enabled port, with switching allowed only at packet boundaries.

## Interface
- NUM_PORTS, 4: number of downstream ports, ≥1.
- DEBOUNCE_CYCLES, 4800: consecutive stable samples needed for connect/disconnect (100 µs at 48 MHz), ≥2.
- RESET_CYCLES, 480000: SE0 bus-reset duration in clk_i cycles (10 ms at 48 MHz), ≥2.
- PW = max(1, $clog2(NUM_PORTS)): width of the port select.

Ports (each line: name, direction, width, meaning):
- clk_i  in  1  clock; the single clock domain.
- rst_i  in  1  reset; synchronous and active-high.
- utmi_data_out_i  in  8  controller TX byte.
- utmi_txvalid_i  in  1  controller TX valid.
- utmi_txready_o  out  1  TX ready to controller.
- utmi_data_in_o  out  8  RX byte to controller.
- utmi_rxvalid_o, utmi_rxactive_o, utmi_rxerror_o  out  1 each  RX status to controller.
- utmi_linestate_o  out  2  linestate of the active port.
- port_data_out_o  out  8*NUM_PORTS  per-port TX byte (port n at [8n+7:8n]).
- port_txvalid_o  out  NUM_PORTS  per-port TX valid.
- port_txready_i  in  NUM_PORTS  per-port TX ready.
- port_data_in_i  in  8*NUM_PORTS  per-port RX byte.
- port_rxvalid_i, port_rxactive_i, port_rxerror_i  in  NUM_PORTS each  per-port RX status.
- port_linestate_i  in  2*NUM_PORTS  per-port linestate (port n at [2n+1:2n]).
- port_reset_assert_o  out  NUM_PORTS  drive SE0 on port (to PHY usb_reset_assert_i).
- port_sel_i  in  PW  requested active port.
- active_port_o  out  PW  currently routed port.
- port_reset_req_i  in  NUM_PORTS  one-cycle request to start a bus reset.
- port_change_clr_i  in  NUM_PORTS  clear the sticky change bit.
- port_connected_o, port_enabled_o, port_lowspeed_o, port_change_o  out  NUM_PORTS each  port status.

## Operation
- Per-port FSM states: DISC, CONN, RESET, EN. The counter is $clog2(max(DEBOUNCE_CYCLES, RESET_CYCLES)+1) bits and saturates.
- **DISC**
  - A qualifying sample is linestate 01 (FS J) or 10 (LS J).
  - The counter counts consecutive qualifying samples that all match the first sample's value. Any mismatch, SE0 or 11 resets it to 0.
  - On the DEBOUNCE_CYCLES-th sample: go to CONN. port_lowspeed latches (1 if 10). port_change sets.
- **CONN**
  - port_reset_req_i moves the port to RESET and clears the counter.
  - SE0 (00) held DEBOUNCE_CYCLES consecutive cycles moves the port to DISC and sets port_change.
- **RESET**
  - port_reset_assert_o is 1. Linestate is ignored.
  - After RESET_CYCLES cycles: go to EN and set port_change.
  - Another reset request in this state is ignored.
- **EN**
  - The disconnect rule is the same as in CONN (to DISC, change set, enabled clears).
  - port_reset_req_i moves the port to RESET; enabled drops.
- Status decode:
  - port_connected_o = state ∈ {CONN, RESET, EN}.
  - port_enabled_o = state == EN.
  - port_lowspeed_o clears on entry to DISC.
- port_reset_req_i is ignored in DISC.
- port_change_o is sticky. If set and port_change_clr_i occur in the same cycle, set wins.
- Routing:
  - active_port_o loads port_sel_i only when the bus is idle: utmi_txvalid_i==0 and port_rxactive_i[active]==0.
  - Out-of-range port_sel_i (≥NUM_PORTS) is ignored.
- Active port in EN:
  - port_txvalid_o[active] = utmi_txvalid_i and port_data_out_o carries utmi_data_out_i.
  - utmi_txready_o = port_txready_i[active].
  - RX outputs mirror the active port.
- Active port not in EN:
  - The TX byte is discarded: utmi_txready_o = utmi_txvalid_i.
  - RX outputs are 0.
- Non-active ports: txvalid 0, data 0x00.
- utmi_linestate_o always mirrors port_linestate_i[active].

## Timing
- Reset values:
  - All FSMs in DISC, counters 0, active_port_o = 0.
  - All status outputs 0; port_reset_assert_o 0.
  - Routing outputs 0. utmi_linestate_o mirrors port 0.
- rst_i mid-operation: any port in RESET immediately deasserts port_reset_assert_o on the next edge. Change bits are lost.
- Status, port_reset_assert_o and active_port_o are registered: they update the cycle after the deciding sample or request.
  - port_reset_assert_o is high for exactly RESET_CYCLES cycles.
  - port_enabled_o rises the cycle it falls.
- UTMI data and handshake routing is combinational from active_port_o, so it adds zero latency.
- A select change takes effect the cycle after an idle cycle.

## Test plan
Bench parameters: NUM_PORTS=2, DEBOUNCE_CYCLES=4, RESET_CYCLES=8.
- Port1 linestate 01 for 4 cycles -> connected[1]=1 and change[1]=1 next cycle, lowspeed[1]=0. Same with a glitch to 00 after 3 cycles -> no connect until 4 more clean cycles.
- Port0 linestate 10 for 4 cycles, then reset_req[0] -> reset_assert[0] high 8 cycles, then enabled[0]=1, lowspeed[0]=1. A second reset_req during RESET -> no extension.
- EN port0, sel=0, send bytes 0x2D,0x00,0x10 with port_txready_i[0] handshaking -> identical bytes/valids on port0, port1 txvalid 0. Set sel=1 while txvalid=1 -> active stays 0 until txvalid low.
- Active port1 in CONN, txvalid=1 data 0xA5 -> port_txvalid_o=0, utmi_txready_o=1. Rxactive on port1 not forwarded.
- EN port0 linestate 00 for 4 cycles -> DISC, enabled 0, change set. change_clr asserted the same cycle as a new change -> change stays 1.
- rst_i asserted mid-RESET -> next cycle all outputs at reset values.
